pc_gen: RTL

Parametrised program-counter generator for the RISC-V core, replacing the fixed 32-bit PC. It sits at the head of fetch and produces the instruction address each cycle. It resolves sequential, PC-relative, absolute, trap and mret redirects with a fixed priority, supports stalls, and raises an instruction-address-misaligned trap. An optional return-address stack predicts `ret` targets.

---
 rtl/pc_gen.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator at the head of fetch.
// Resolves trap, mret, stall, ret, branch and abs_branch redirects with fixed
// priority, raises a misaligned-target trap and holds the trap PC in epc.
// Optional return-address stack is built only when PC_RAS_EN is defined;
// without it, ret acts as an absolute jump and the RAS flags are constant.
module pc_gen #(
   parameter int unsigned           WIDTH        = 32,
   parameter logic [WIDTH-1:0]      RESET_VECTOR = '0,
   parameter int unsigned           RAS_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             branch,
   input  logic             abs_branch,
   input  logic [WIDTH-1:0] immediate,
   input  logic             call,
   input  logic             ret,
   input  logic             trap,
   input  logic [WIDTH-1:0] trap_vec,
   input  logic             mret,
   output logic [WIDTH-1:0] pc_out,
   output logic             pc_valid,
   output logic [WIDTH-1:0] epc,
   output logic             misalign,
   output logic             ras_empty,
   output logic             ras_full
);

   typedef enum logic [1:0] {
      S_RESET,
      S_RUN,
      S_FLUSH
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] epc_q;
   logic             valid_q;
   logic             misalign_q;

   logic [WIDTH-1:0] seqPc;
   logic [WIDTH-1:0] relTarget;
   logic [WIDTH-1:0] absTarget;
   logic [WIDTH-1:0] target;
   logic             redirect;
   logic             misTarget;
   logic             rasHit;
   logic [WIDTH-1:0] rasTop;

   assign seqPc     = pc_q + WIDTH'(4);
   assign relTarget = pc_q + immediate;
   assign absTarget = {immediate[WIDTH-1:1], 1'b0};

   // Select the redirect target among ret, branch and abs_branch; a ret that
   // finds the stack empty falls back to the absolute immediate target.
   always_comb begin
      redirect = 1'b0;
      target   = seqPc;
      if (ret) begin
         redirect = 1'b1;
         target   = rasHit ? rasTop : absTarget;
      end else if (branch) begin
         redirect = 1'b1;
         target   = relTarget;
      end else if (abs_branch) begin
         redirect = 1'b1;
         target   = absTarget;
      end
   end

   assign misTarget = redirect & target[1];

   // Main FSM: reset/run/flush sequencing, PC and epc update, misalign pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_RESET;
         pc_q       <= RESET_VECTOR;
         epc_q      <= '0;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= 1'b0;
         case (state_q)
            S_RESET, S_FLUSH: begin
               state_q <= S_RUN;
               valid_q <= 1'b1;
            end
            S_RUN: begin
               if (trap) begin
                  pc_q    <= trap_vec;
                  epc_q   <= pc_q;
                  state_q <= S_FLUSH;
                  valid_q <= 1'b0;
               end else if (mret) begin
                  pc_q <= epc_q;
               end else if (!stall) begin
                  if (misTarget) begin
                     pc_q       <= trap_vec;
                     epc_q      <= pc_q;
                     misalign_q <= 1'b1;
                     state_q    <= S_FLUSH;
                     valid_q    <= 1'b0;
                  end else begin
                     pc_q <= target;
                  end
               end
            end
            default: begin
               state_q <= S_RESET;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign pc_out   = pc_q;
   assign pc_valid = valid_q;
   assign epc      = epc_q;
   assign misalign = misalign_q;

`ifdef PC_RAS_EN
   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] rasMem_q [RAS_DEPTH];
   logic [PTR_W-1:0] top_q;
   logic [PTR_W-1:0] top_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             empty_q;
   logic             full_q;
   logic             rasUpdate;
   logic             pushReq;
   logic             popReq;
   logic             wrEn;
   logic [PTR_W-1:0] wrPtr;

   assign rasHit    = (count_q != '0);
   assign rasTop    = rasMem_q[top_q];
   assign pushReq   = call & (ret | branch | abs_branch);
   assign popReq    = ret & rasHit;
   assign rasUpdate = !rst && (state_q == S_RUN) && !trap && !mret && !stall && !misTarget;

   // Stack pointer/count next state; a simultaneous pop and push rewrites
   // the current top slot so the depth does not change.
   always_comb begin
      top_d   = top_q;
      count_d = count_q;
      wrEn    = 1'b0;
      wrPtr   = top_q;
      if (rasUpdate) begin
         if (popReq && pushReq) begin
            wrEn  = 1'b1;
            wrPtr = top_q;
         end else if (popReq) begin
            top_d   = top_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
         end else if (pushReq) begin
            top_d = top_q + PTR_W'(1);
            wrPtr = top_q + PTR_W'(1);
            wrEn  = 1'b1;
            if (count_q != CNT_W'(RAS_DEPTH)) begin
               count_d = count_q + CNT_W'(1);
            end
         end
      end
   end

   // Register pointer, count and the empty/full flags derived from the new count.
   always_ff @(posedge clk) begin
      if (rst) begin
         top_q   <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         top_q   <= top_d;
         count_q <= count_d;
         empty_q <= (count_d == '0);
         full_q  <= (count_d == CNT_W'(RAS_DEPTH));
      end
   end

   // Return-address storage; when full, the push wraps onto the oldest entry.
   always_ff @(posedge clk) begin
      if (wrEn) begin
         rasMem_q[wrPtr] <= seqPc;
      end
   end

   assign ras_empty = empty_q;
   assign ras_full  = full_q;
`else
   logic unusedCall;

   assign unusedCall = call;
   assign rasHit     = 1'b0;
   assign rasTop     = '0;
   assign ras_empty  = 1'b1;
   assign ras_full   = 1'b0;
`endif

endmodule
